// File: rtl/mux_scan_controller.sv
// Scan sequencer for a 32:1 single-bit mux: steps sel through channels 0..31,
// settles, samples, and publishes a 32-bit snapshot frame plus change mask.
module mux_scan_controller #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        continuous,
    input  logic        abort,
    input  logic        mux_o,
    output logic [4:0]  sel,
    output logic        busy,
    output logic [31:0] frame,
    output logic [31:0] changed,
    output logic        frame_valid
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    state_t      state_q, state_d;
    logic [4:0]  sel_q, sel_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] shadow_q, shadow_d;
    logic [31:0] frame_q, frame_d;
    logic [31:0] changed_q, changed_d;
    logic        frame_valid_q, frame_valid_d;
    logic        busy_q, busy_d;

    // Frame hand-off: frame_valid is a one-cycle strobe with no back-pressure;
    // the consumer must capture frame/changed in the cycle the strobe is high.
    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        cnt_d         = cnt_q;
        shadow_d      = shadow_q;
        frame_d       = frame_q;
        changed_d     = changed_q;
        frame_valid_d = 1'b0;

        if (abort) begin
            state_d = IDLE;
            sel_d   = 5'd0;
            cnt_d   = 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    sel_d = 5'd0;
                    if (start || continuous) begin
                        state_d = SETTLE;
                        cnt_d   = 8'd0;
                    end
                end
                SETTLE: begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == SETTLE_LAST) begin
                        state_d = SAMPLE;
                    end
                end
                SAMPLE: begin
                    shadow_d[sel_q] = mux_o;
                    if (sel_q == 5'd31) begin
                        state_d = DONE;
                    end else begin
                        state_d = SETTLE;
                        sel_d   = sel_q + 5'd1;
                        cnt_d   = 8'd0;
                    end
                end
                DONE: begin
                    frame_d       = shadow_q;
                    changed_d     = shadow_q ^ frame_q;
                    frame_valid_d = 1'b1;
                    sel_d         = 5'd0;
                    cnt_d         = 8'd0;
                    // Continuous mode restarts the same edge the strobe rises.
                    state_d       = continuous ? SETTLE : IDLE;
                end
                default: begin
                    state_d = IDLE;
                    sel_d   = 5'd0;
                    cnt_d   = 8'd0;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            sel_q         <= 5'd0;
            cnt_q         <= 8'd0;
            shadow_q      <= 32'd0;
            frame_q       <= 32'd0;
            changed_q     <= 32'd0;
            frame_valid_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            cnt_q         <= cnt_d;
            shadow_q      <= shadow_d;
            frame_q       <= frame_d;
            changed_q     <= changed_d;
            frame_valid_q <= frame_valid_d;
            busy_q        <= busy_d;
        end
    end

    assign sel         = sel_q;
    assign busy        = busy_q;
    assign frame       = frame_q;
    assign changed     = changed_q;
    assign frame_valid = frame_valid_q;

endmodule
